// File: rtl/operand_fetch_if.sv
// Instruction-in / operand-out handshake bundle for the operand fetch stage.
// The master drives instructions and consumes operands. The slave is the stage itself.
interface operand_fetch_if #(
    parameter int REG_SIZE  = 5,
    parameter int CODE_SIZE = 6,
    parameter int DATA_SIZE = 32,
    parameter int IMM_SIZE  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CODE_SIZE-1:0] in_code;
    logic [REG_SIZE-1:0]  in_ri;
    logic [REG_SIZE-1:0]  in_rj;
    logic [REG_SIZE-1:0]  in_rk;
    logic [IMM_SIZE-1:0]  in_imm;

    logic                 out_valid;
    logic                 out_ready;
    logic [CODE_SIZE-1:0] out_code;
    logic [REG_SIZE-1:0]  out_ri;
    logic [IMM_SIZE-1:0]  out_imm;
    logic [DATA_SIZE-1:0] out_j;
    logic [DATA_SIZE-1:0] out_k;

    modport master (
        output in_valid, in_code, in_ri, in_rj, in_rk, in_imm, out_ready,
        input  in_ready, out_valid, out_code, out_ri, out_imm, out_j, out_k
    );

    modport slave (
        input  in_valid, in_code, in_ri, in_rj, in_rk, in_imm, out_ready,
        output in_ready, out_valid, out_code, out_ri, out_imm, out_j, out_k
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: RF read addressing, one-entry ID/EX register, and a
// pending-write scoreboard that blocks RAW/WAW hazards until RF writeback.
module operand_fetch #(
    parameter int REG_SIZE  = 5,
    parameter int CODE_SIZE = 6,
    parameter int DATA_SIZE = 32,
    parameter int IMM_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_fetch_if.slave       bus,
    output logic [REG_SIZE-1:0]  rf_rj,
    output logic [REG_SIZE-1:0]  rf_rk,
    input  logic [DATA_SIZE-1:0] rf_j_data,
    input  logic [DATA_SIZE-1:0] rf_k_data,
    input  logic [CODE_SIZE-1:0] wb_code,
    input  logic [REG_SIZE-1:0]  wb_ri,
    input  logic                 flush,
    output logic [15:0]          stall_cnt
);
    localparam int NREG = 1 << REG_SIZE;
    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_eff;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic            wb_commit;
    logic            out_writer;
    logic            busy_j;
    logic            busy_k;
    logic            busy_i;
    logic            hazard;
    logic            accept;
    logic            depart;

    function automatic logic is_writer(input logic [CODE_SIZE-1:0] code);
        return (code == CODE_SIZE'(1)) || (code == CODE_SIZE'(2));
    endfunction

    assign rf_rj = bus.in_rj;
    assign rf_rk = bus.in_rk;

    // The RF commits at mid-cycle, so a writeback that is retiring clears its hazard in the same cycle.
    always_comb begin
        wb_commit   = is_writer(wb_code);
        clr_mask    = wb_commit ? (ONE << wb_ri) : '0;
        pending_eff = pending & ~clr_mask;
        out_writer  = bus.out_valid & is_writer(bus.out_code);
        busy_j      = pending_eff[bus.in_rj] | (out_writer & (bus.out_ri == bus.in_rj));
        busy_k      = pending_eff[bus.in_rk] | (out_writer & (bus.out_ri == bus.in_rk));
        busy_i      = pending_eff[bus.in_ri] | (out_writer & (bus.out_ri == bus.in_ri));
        hazard      = bus.in_valid & (bus.in_code != '0)
                      & (busy_j | busy_k | (is_writer(bus.in_code) & busy_i));
        bus.in_ready = ~hazard & (~bus.out_valid | bus.out_ready | flush);
        accept      = bus.in_valid & bus.in_ready;
        depart      = bus.out_valid & bus.out_ready & ~flush;
        set_mask    = (depart & out_writer) ? (ONE << bus.out_ri) : '0;
    end

    // A register that departs and commits in the same cycle stays pending, so the set takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_code  <= '0;
            bus.out_ri    <= '0;
            bus.out_imm   <= '0;
            bus.out_j     <= '0;
            bus.out_k     <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_code  <= bus.in_code;
            bus.out_ri    <= bus.in_ri;
            bus.out_imm   <= bus.in_imm;
            bus.out_j     <= rf_j_data;
            bus.out_k     <= rf_k_data;
        end else if (bus.out_ready || flush) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboarded bench for operand_fetch: hazard stalls, backpressure, flush,
// stall counter saturation and asynchronous reset.
module tb_operand_fetch;
    logic        clk;
    logic        rst;
    logic [4:0]  rf_rj;
    logic [4:0]  rf_rk;
    logic [31:0] rf_j_data;
    logic [31:0] rf_k_data;
    logic [5:0]  wb_code;
    logic [4:0]  wb_ri;
    logic        flush;
    logic [15:0] stall_cnt;

    operand_fetch_if #(.REG_SIZE(5), .CODE_SIZE(6), .DATA_SIZE(32), .IMM_SIZE(16)) bus ();

    operand_fetch #(.REG_SIZE(5), .CODE_SIZE(6), .DATA_SIZE(32), .IMM_SIZE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rf_rj     (rf_rj),
        .rf_rk     (rf_rk),
        .rf_j_data (rf_j_data),
        .rf_k_data (rf_k_data),
        .wb_code   (wb_code),
        .wb_ri     (wb_ri),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [5:0]  code;
        logic [4:0]  ri;
        logic [15:0] imm;
        logic [31:0] j;
        logic [31:0] k;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf_mem [32];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_stall = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_j_data = rf_mem[rf_rj];
    assign rf_k_data = rf_mem[rf_rk];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] code, input logic [4:0] ri, input logic [4:0] rj,
                           input logic [4:0] rk, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        bus.in_ri    = ri;
        bus.in_rj    = rj;
        bus.in_rk    = rk;
        bus.in_imm   = imm;
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        #1;
    endtask

    task automatic wb_clear(input logic [5:0] code, input logic [4:0] r);
        wb_code = code;
        wb_ri   = r;
        tick();
        wb_code = '0;
        wb_ri   = '0;
    endtask

    // Retire the departing/flushed entry before recording the newly accepted one.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.out_valid && (bus.out_ready || flush)) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", bus.out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    if (!flush) begin
                        chk("sb_code", bus.out_code, e.code);
                        chk("sb_ri",   bus.out_ri,   e.ri);
                        chk("sb_imm",  bus.out_imm,  e.imm);
                        chk("sb_j",    bus.out_j,    e.j);
                        chk("sb_k",    bus.out_k,    e.k);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.code = bus.in_code;
                e.ri   = bus.in_ri;
                e.imm  = bus.in_imm;
                e.j    = rf_mem[bus.in_rj];
                e.k    = rf_mem[bus.in_rk];
                sb.push_back(e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i * 2 + 3);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_ri     = '0;
        bus.in_rj     = '0;
        bus.in_rk     = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b1;
        wb_code       = '0;
        wb_ri         = '0;
        flush         = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_j", bus.out_j, 32'd0);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_pending", dut.pending, 32'd0);
        rst = 1'b0;
        tick();

        // ALU r3 = r1 op r2, then a dependent ALU reading r3 back-to-back
        present(6'd1, 5'd3, 5'd1, 5'd2, 16'h0011);
        chk("t1_rf_rj", rf_rj, 5'd1);
        chk("t1_in_ready", bus.in_ready, 1'b1);
        tick();
        chk("t1_out_valid", bus.out_valid, 1'b1);
        chk("t1_out_j", bus.out_j, 32'd5);
        chk("t1_out_k", bus.out_k, 32'd7);
        present(6'd1, 5'd5, 5'd3, 5'd0, 16'h0022);
        for (int i = 0; i < 3; i++) begin
            chk("t2_in_ready_stall", bus.in_ready, 1'b0);
            tick();
            exp_stall++;
            if (i == 0) chk("t1_pending3", dut.pending[3], 1'b1);
        end
        wb_code = 6'd1;
        wb_ri   = 5'd3;
        #1;
        chk("t2_in_ready_wb", bus.in_ready, 1'b1);
        tick();
        wb_code = '0;
        idle();
        chk("t2_stall", stall_cnt, exp_stall);
        tick();
        wb_clear(6'd1, 5'd5);

        // LW r4 then SW targeting r4 (store data from r4)
        present(6'd2, 5'd4, 5'd0, 5'd0, 16'h0033);
        tick();
        present(6'd3, 5'd4, 5'd1, 5'd4, 16'h0034);
        for (int i = 0; i < 2; i++) begin
            chk("t3_in_ready_stall", bus.in_ready, 1'b0);
            tick();
            exp_stall++;
        end
        wb_code = 6'd2;
        wb_ri   = 5'd4;
        #1;
        chk("t3_in_ready_wb", bus.in_ready, 1'b1);
        tick();
        wb_code = '0;
        idle();
        chk("t3_stall", stall_cnt, exp_stall);
        tick();

        // Backpressure: held entry must stay stable and block even a NOP
        bus.out_ready = 1'b0;
        present(6'd1, 5'd7, 5'd1, 5'd2, 16'h0044);
        tick();
        present(6'd0, 5'd0, 5'd0, 5'd0, 16'h0055);
        for (int i = 0; i < 3; i++) begin
            chk("t4_in_ready", bus.in_ready, 1'b0);
            tick();
            chk("t4_out_valid", bus.out_valid, 1'b1);
            chk("t4_out_ri", bus.out_ri, 5'd7);
            chk("t4_out_imm", bus.out_imm, 16'h0044);
            chk("t4_out_j", bus.out_j, 32'd5);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_in_ready_go", bus.in_ready, 1'b1);
        tick();
        idle();
        tick();
        chk("t4_stall", stall_cnt, exp_stall);
        wb_clear(6'd1, 5'd7);

        // Flush a held writer while loading a new entry in the same cycle
        bus.out_ready = 1'b0;
        present(6'd1, 5'd6, 5'd1, 5'd1, 16'h0066);
        tick();
        chk("t5_held", bus.out_valid, 1'b1);
        flush = 1'b1;
        present(6'd3, 5'd9, 5'd2, 5'd3, 16'h0077);
        chk("t5_in_ready_flush", bus.in_ready, 1'b1);
        tick();
        flush = 1'b0;
        idle();
        chk("t5_new_valid", bus.out_valid, 1'b1);
        chk("t5_new_code", bus.out_code, 6'd3);
        chk("t5_new_ri", bus.out_ri, 5'd9);
        chk("t5_pending6", dut.pending[6], 1'b0);
        bus.out_ready = 1'b1;
        tick();
        chk("t5_drained", bus.out_valid, 1'b0);
        tick();
        chk("t5_pending_all", dut.pending, 32'd0);
        chk("t5_sb_empty", sb.size(), 0);

        // Saturate the stall counter behind a held writer, then reset mid-cycle
        bus.out_ready = 1'b0;
        present(6'd1, 5'd10, 5'd1, 5'd2, 16'h0088);
        tick();
        present(6'd1, 5'd11, 5'd10, 5'd0, 16'h0099);
        chk("t6_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            tick();
            if (exp_stall != 16'hFFFF) exp_stall++;
        end
        chk("t6_stall_sat", stall_cnt, exp_stall);
        chk("t6_stall_ffff", stall_cnt, 16'hFFFF);
        chk("t6_held_ri", bus.out_ri, 5'd10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", bus.out_valid, 1'b0);
        chk("t6_rst_ri", bus.out_ri, 5'd0);
        chk("t6_rst_j", bus.out_j, 32'd0);
        chk("t6_rst_stall", stall_cnt, 16'd0);
        chk("t6_rst_pending", dut.pending, 32'd0);
        idle();
        tick();
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
